msrv32_imm_gen_pipe: RTL and testbench

Parametrised, registered successor to the combinational immediate generator. It accepts instr[31:7] plus an immediate-type code through a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width, with one-cycle latency and full throughput. It sits between decode and the operand-select stage and decouples decode from downstream stalls through a 2-entry output buffer.

---
 rtl/msrv32_imm_pkg.sv | 37 +++
 rtl/msrv32_imm_fifo.sv | 94 +++++++++
 rtl/msrv32_imm_gen_pipe.sv | 61 ++++++
 tb/tb_msrv32_imm_gen_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_imm_pkg.sv
// Shared definitions for the pipelined immediate generator.
//   - IMM_* : 3-bit immediate format codes carried alongside instr[31:7].
//   - imm_format(): builds the immediate from instr[31:7] at the widest
//     supported XLEN (64). Narrower builds take the low XLEN bits, which is
//     exact because every format is either sign- or zero-extended.
package msrv32_imm_pkg;

    localparam int unsigned MAX_XLEN = 64;

    localparam logic [2:0] IMM_I0  = 3'b000;
    localparam logic [2:0] IMM_I   = 3'b001;
    localparam logic [2:0] IMM_S   = 3'b010;
    localparam logic [2:0] IMM_B   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_J   = 3'b101;
    localparam logic [2:0] IMM_CSR = 3'b110;
    localparam logic [2:0] IMM_ILL = 3'b111;

    function automatic logic [MAX_XLEN-1:0] imm_format(input logic [24:0] instr,
                                                        input logic [2:0]  imm_type);
        // Indexed by real instruction bit numbers to match the ISA tables.
        logic [31:7] i;
        logic [MAX_XLEN-1:0] imm;
        i = instr;
        case (imm_type)
            IMM_S:   imm = {{52{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm = {{32{i[31]}}, i[31:12], 12'b0};
            IMM_J:   imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_CSR: imm = {59'b0, i[19:15]};
            // I0, I and the illegal code all produce the I-type value.
            default: imm = {{52{i[31]}}, i[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/msrv32_imm_fifo.sv
// Generic Depth x Width synchronous FIFO with occupancy count, synchronous
// flush and asynchronous active-high reset.
//   clk_i, rst_i          : clock, async active-high reset
//   flush_i               : drop all entries (wins over push/pop)
//   wr_valid_i/wr_ready_o : write handshake, wr_data_i is the entry
//   rd_valid_o/rd_ready_i : read handshake, rd_data_o is the head entry
//   count_o               : current occupancy, 0..Depth
module msrv32_imm_fifo #(
    parameter int unsigned Width = 33,
    parameter int unsigned Depth = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [Width-1:0]         wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [Width-1:0]         rd_data_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    // Last head shown, so the data output holds steady once the FIFO drains.
    logic [Width-1:0] last_q, last_d;
    // Keeps wr_ready low during reset and up to the first edge after release.
    logic             alive_q;

    logic push, pop;

    assign wr_ready_o = alive_q && (count_q < FullCnt);
    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : last_q;
    assign count_o    = count_q;

    assign push = wr_valid_i & wr_ready_o;
    assign pop  = rd_valid_o & rd_ready_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = rd_valid_o ? mem_q[rd_ptr_q] : last_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wr_data_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < int'(Depth); k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
            alive_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            alive_q  <= 1'b1;
        end
    end

endmodule

// File: rtl/msrv32_imm_gen_pipe.sv
// Registered immediate generator: formats instr[31:7] by imm_type_in on
// input and buffers {illegal, immediate} in a small FIFO towards the
// operand-select stage. One-cycle latency, full throughput.
//   ms_riscv32_mp_clk_in / ms_riscv32_mp_rst_in : clock, async active-high reset
//   flush_in                     : discard all buffered entries
//   in_valid/in_ready            : input handshake (instr_in, imm_type_in)
//   out_valid/out_ready          : output handshake (imm_out, illegal_out)
//   count_out                    : buffer occupancy
module msrv32_imm_gen_pipe
    import msrv32_imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_in,
    input  logic                    flush_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [24:0]             instr_in,
    input  logic [2:0]              imm_type_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         imm_out,
    output logic                    illegal_out,
    output logic [$clog2(DEPTH):0]  count_out
);

    logic [MAX_XLEN-1:0] imm_full;
    logic [XLEN:0]       wr_data;
    logic [XLEN:0]       rd_data;
    logic                unused_imm_hi;

    always_comb begin
        imm_full = imm_format(instr_in, imm_type_in);
        wr_data  = {(imm_type_in == IMM_ILL), imm_full[XLEN-1:0]};
    end

    // Upper bits are only consumed in 64-bit builds.
    assign unused_imm_hi = ^imm_full;

    msrv32_imm_fifo #(
        .Width (XLEN + 1),
        .Depth (DEPTH)
    ) u_fifo (
        .clk_i      (ms_riscv32_mp_clk_in),
        .rst_i      (ms_riscv32_mp_rst_in),
        .flush_i    (flush_in),
        .wr_valid_i (in_valid),
        .wr_ready_o (in_ready),
        .wr_data_i  (wr_data),
        .rd_valid_o (out_valid),
        .rd_ready_i (out_ready),
        .rd_data_o  (rd_data),
        .count_o    (count_out)
    );

    assign imm_out     = rd_data[XLEN-1:0];
    assign illegal_out = rd_data[XLEN];

endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
module tb_msrv32_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [24:0] instr = '0;
    logic [2:0]  imm_type = '0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] imm;
    logic [1:0]  count;
    logic        in_ready_w, out_valid_w, illegal_w;
    logic [63:0] imm_w;
    logic [1:0]  count_w;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msrv32_imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .flush_in             (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .instr_in             (instr),
        .imm_type_in          (imm_type),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .imm_out              (imm),
        .illegal_out          (illegal),
        .count_out            (count)
    );

    msrv32_imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut_w (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .flush_in             (flush),
        .in_valid             (in_valid),
        .in_ready             (in_ready_w),
        .instr_in             (instr),
        .imm_type_in          (imm_type),
        .out_valid            (out_valid_w),
        .out_ready            (out_ready),
        .imm_out              (imm_w),
        .illegal_out          (illegal_w),
        .count_out            (count_w)
    );

    typedef struct {
        string       name;
        logic [2:0]  typ;
        logic [31:0] word;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] w);
        in_valid = v;
        imm_type = t;
        instr    = w[31:7];
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"i_type",   3'b001, 32'hFFF00093, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vecs[1] = '{"b_type",   3'b011, 32'hFE000EE3, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[2] = '{"u_type",   3'b100, 32'h12345037, 64'h00000000_12345000, 1'b0};
        vecs[3] = '{"j_type",   3'b101, 32'h0080006F, 64'h00000000_00000008, 1'b0};
        vecs[4] = '{"csr_zimm", 3'b110, 32'h000A8000, 64'h00000000_00000015, 1'b0};
        vecs[5] = '{"s_type",   3'b010, 32'h80000F80, 64'hFFFFFFFF_FFFFF81F, 1'b0};
        vecs[6] = '{"i0_type",  3'b000, 32'h7FF00000, 64'h00000000_000007FF, 1'b0};
        vecs[7] = '{"u_neg",    3'b100, 32'h80000037, 64'hFFFFFFFF_80000000, 1'b0};
        vecs[8] = '{"illegal",  3'b111, 32'h80100000, 64'hFFFFFFFF_FFFFF801, 1'b1};

        // Reset state
        #1;
        check("rst_in_ready",  {63'b0, in_ready}, 64'd0);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_count",     {62'b0, count}, 64'd0);
        check("rst_imm",       {32'b0, imm}, 64'd0);
        check("rst_imm_w",     imm_w, 64'd0);
        check("rst_illegal",   {63'b0, illegal}, 64'd0);
        after_edge();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_in_ready_pre", {63'b0, in_ready}, 64'd0);
        after_edge();
        check("rel_in_ready", {63'b0, in_ready}, 64'd1);

        // Format table, both widths
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(1'b1, vecs[k].typ, vecs[k].word);
            after_edge();
            drive(1'b0, 3'b000, 32'h0);
            check({vecs[k].name, "_valid"}, {63'b0, out_valid}, 64'd1);
            check({vecs[k].name, "_x32"}, {32'b0, imm}, {32'b0, vecs[k].exp[31:0]});
            check({vecs[k].name, "_x64"}, imm_w, vecs[k].exp);
            check({vecs[k].name, "_ill"}, {63'b0, illegal}, {63'b0, vecs[k].ill});
            check({vecs[k].name, "_ill_w"}, {63'b0, illegal_w}, {63'b0, vecs[k].ill});
        end
        after_edge();
        check("drain_empty", {63'b0, out_valid}, 64'd0);

        // Backpressure: three offered, two accepted
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h00A00000);
        after_edge();
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h00B00000);
        after_edge();
        check("bp_count2", {62'b0, count}, 64'd2);
        check("bp_in_ready0", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h00C00000);
        after_edge();
        check("bp_still2", {62'b0, count}, 64'd2);
        check("bp_head_a", {32'b0, imm}, 64'h00A);
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0);
        out_ready = 1'b1;
        after_edge();
        check("bp_head_b", {32'b0, imm}, 64'h00B);
        check("bp_count1", {62'b0, count}, 64'd1);
        after_edge();
        check("bp_empty", {63'b0, out_valid}, 64'd0);
        check("bp_hold", {32'b0, imm}, 64'h00B);

        // Streaming 64 back-to-back
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            drive(1'b1, 3'b001, (32'(k) + 32'd256) << 20);
            after_edge();
            check("stream_valid", {63'b0, out_valid}, 64'd1);
            check("stream_data", {32'b0, imm}, 64'(k + 256));
            check("stream_count_le1", {63'b0, (count > 2'd1)}, 64'd0);
        end
        @(negedge clk);
        drive(1'b0, 3'b000, 32'h0);
        after_edge();
        check("stream_end", {62'b0, count}, 64'd0);

        // Flush at count=2 with push offered and pop taken
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 3'b001, 32'h00100000);
            after_edge();
        end
        check("fl_full", {62'b0, count}, 64'd2);
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'b001, 32'h07700000);
        after_edge();
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'h0);
        check("fl_count0", {62'b0, count}, 64'd0);
        check("fl_out_valid0", {63'b0, out_valid}, 64'd0);
        after_edge();
        check("fl_no_ghost", {62'b0, count}, 64'd0);

        // Flush at count=1 with an actual handshake that must be dropped
        out_ready = 1'b0;
        @(negedge clk);
        drive(1'b1, 3'b001, 32'h00100000);
        after_edge();
        @(negedge clk);
        flush = 1'b1;
        drive(1'b1, 3'b001, 32'h07700000);
        #1;
        check("fl1_in_ready", {63'b0, in_ready}, 64'd1);
        after_edge();
        flush = 1'b0;
        drive(1'b0, 3'b000, 32'h0);
        check("fl1_count0", {62'b0, count}, 64'd0);

        // Reset mid-stream with two entries held
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(1'b1, 3'b100, 32'h55555000);
            after_edge();
        end
        drive(1'b0, 3'b000, 32'h0);
        check("rm_full", {62'b0, count}, 64'd2);
        #1;
        rst = 1'b1;
        #1;
        check("rm_out_valid", {63'b0, out_valid}, 64'd0);
        check("rm_count", {62'b0, count}, 64'd0);
        check("rm_imm", {32'b0, imm}, 64'd0);
        check("rm_in_ready", {63'b0, in_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        after_edge();
        check("rm_in_ready_after", {63'b0, in_ready}, 64'd1);
        check("rm_count_after", {62'b0, count}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
